// File: rtl/rv_pipe_pkg.sv
// ============================================================================
// Module  : rv_pipe_pkg
// Brief   : Shared constants for the RV32 5-stage pipeline datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pipe_pkg;
  localparam int          XLEN        = 32;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          INSTR_BYTES = 4;
  // Pipeline registers clear to all-zero, not to an encoded NOP.
  localparam logic        IFID_RST    = 1'b0;
endpackage

`default_nettype wire

// File: rtl/pipe_reg_en_clr.sv
// ============================================================================
// Module  : pipe_reg_en_clr
// Brief   : Register with async active-low reset, sync enable and sync clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_en_clr #(
  parameter int           W   = 32,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear outranks enable so a flush lands even while the stage is stalled.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/if_stage_datapath.sv
// ============================================================================
// Module  : if_stage_datapath
// Brief   : IF stage: PC register, PC+4, next-PC select and IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_datapath
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = rv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pipe_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  logic [XLEN-1:0]   pc_next;
  logic [3*XLEN-1:0] ifid_d;
  logic [3*XLEN-1:0] ifid_q;

  assign PCPlus4F = PCF + XLEN'(INSTR_BYTES);
  assign pc_next  = PCSrcE ? PCTargetE : PCPlus4F;

  // A redirect presented while StallF is high is dropped with the hold.
  pipe_reg_en_clr #(
    .W   (XLEN),
    .RST (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (!StallF),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (PCF)
  );

  assign ifid_d = {InstrF, PCF, PCPlus4F};

  pipe_reg_en_clr #(
    .W   (3*XLEN),
    .RST ({(3*XLEN){IFID_RST}})
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (!StallD),
    .clr   (FlushD),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign InstrD   = ifid_q[3*XLEN-1:2*XLEN];
  assign PCD      = ifid_q[2*XLEN-1:XLEN];
  assign PCPlus4D = ifid_q[XLEN-1:0];

endmodule

`default_nettype wire

// File: tb/tb_if_stage_datapath.sv
// ============================================================================
// Module  : tb_if_stage_datapath
// Brief   : Scoreboard bench for the IF stage datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage_datapath;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;

  ifid_t       exp_q[$];
  ifid_t       exp_last;
  logic [31:0] model_pc;
  int          n_cmp = 0;
  int          n_bad = 0;

  if_stage_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   imem = 32'h0050_0113;
      32'h4:   imem = 32'h00C0_0193;
      32'h8:   imem = 32'h0020_81B3;
      32'hC:   imem = 32'h4030_8233;
      default: imem = 32'h0000_0013 ^ {a[29:0], 2'b00};
    endcase
  endfunction

  assign InstrF = imem(PCF);

  // Drive one cycle of controls, predict the IF/ID contents and next PC.
  task automatic step(input logic sf, input logic sd, input logic fd,
                      input logic src, input logic [31:0] tgt);
    ifid_t e;
    @(negedge clk);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = src; PCTargetE = tgt;
    if (fd)      e = '0;
    else if (sd) e = exp_last;
    else         e = '{instr: imem(model_pc), pc: model_pc, pc4: model_pc + 32'd4};
    exp_last = e;
    exp_q.push_back(e);
    if (!sf) model_pc = src ? tgt : model_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    StallF = 1'($urandom); StallD = 1'($urandom); FlushD = 1'($urandom);
    PCSrcE = 1'($urandom); PCTargetE = $urandom;
    #2;
    n_cmp++;
    if ({PCF, InstrD, PCD, PCPlus4D} !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_async: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h want all 0",
               PCF, InstrD, PCD, PCPlus4D);
    end
    #6;
    n_cmp++;
    if ({PCF, InstrD, PCD, PCPlus4D} !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_hold_edge: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h want all 0",
               PCF, InstrD, PCD, PCPlus4D);
    end
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    reset = 1'b1;
    model_pc = 32'h0;
    exp_last = '0;
  endtask

  task automatic test_sequential();
    ifid_t e;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({InstrD, PCD, PCPlus4D} !== e) begin
        n_bad++;
        $display("FAIL seq_d[%0d]: got %h %h %h want %h %h %h", i, InstrD, PCD, PCPlus4D,
                 e.instr, e.pc, e.pc4);
      end
      n_cmp++;
      if (PCF !== model_pc || PCPlus4F !== model_pc + 32'd4) begin
        n_bad++;
        $display("FAIL seq_pc[%0d]: got %h/%h want %h/%h", i, PCF, PCPlus4F,
                 model_pc, model_pc + 32'd4);
      end
    end
  endtask

  task automatic test_branch();
    ifid_t e;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, (i == 0), 32'h40);
      e = exp_q.pop_front();
      n_cmp++;
      if ({InstrD, PCD, PCPlus4D} !== e) begin
        n_bad++;
        $display("FAIL branch_d[%0d]: got %h %h %h want %h %h %h", i, InstrD, PCD,
                 PCPlus4D, e.instr, e.pc, e.pc4);
      end
      n_cmp++;
      if (PCF !== model_pc) begin
        n_bad++;
        $display("FAIL branch_pc[%0d]: got %h want %h", i, PCF, model_pc);
      end
    end
  endtask

  task automatic test_stall();
    ifid_t e;
    logic  sf_tab [5] = '{0, 0, 1, 1, 0};
    logic  src_tab[5] = '{1, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      step(sf_tab[i], sf_tab[i], 0, src_tab[i], (i == 0) ? 32'h10 : 32'h80);
      e = exp_q.pop_front();
      n_cmp++;
      if ({InstrD, PCD, PCPlus4D} !== e) begin
        n_bad++;
        $display("FAIL stall_d[%0d]: got %h %h %h want %h %h %h", i, InstrD, PCD,
                 PCPlus4D, e.instr, e.pc, e.pc4);
      end
      n_cmp++;
      if (PCF !== model_pc) begin
        n_bad++;
        $display("FAIL stall_pc[%0d]: got %h want %h", i, PCF, model_pc);
      end
    end
  endtask

  task automatic test_flush();
    ifid_t e;
    logic  fd_tab[3] = '{0, 1, 0};
    logic  sd_tab[3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      step(0, sd_tab[i], fd_tab[i], 0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({InstrD, PCD, PCPlus4D} !== e) begin
        n_bad++;
        $display("FAIL flush_d[%0d]: got %h %h %h want %h %h %h", i, InstrD, PCD,
                 PCPlus4D, e.instr, e.pc, e.pc4);
      end
      n_cmp++;
      if (PCF !== model_pc) begin
        n_bad++;
        $display("FAIL flush_pc[%0d]: got %h want %h", i, PCF, model_pc);
      end
    end
  endtask

  task automatic test_wrap_and_midreset();
    ifid_t e;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, (i == 0), 32'hFFFF_FFFC);
      e = exp_q.pop_front();
      n_cmp++;
      if ({InstrD, PCD, PCPlus4D} !== e) begin
        n_bad++;
        $display("FAIL wrap_d[%0d]: got %h %h %h want %h %h %h", i, InstrD, PCD,
                 PCPlus4D, e.instr, e.pc, e.pc4);
      end
      n_cmp++;
      if (PCF !== model_pc || PCPlus4F !== model_pc + 32'd4) begin
        n_bad++;
        $display("FAIL wrap_pc[%0d]: got %h/%h want %h/%h", i, PCF, PCPlus4F,
                 model_pc, model_pc + 32'd4);
      end
    end
    step(0, 0, 0, 0, 32'h0);
    void'(exp_q.pop_front());
    // Pull reset mid-cycle with every control active.
    StallF = 1; StallD = 1; FlushD = 1; PCSrcE = 1; PCTargetE = 32'h200;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({PCF, InstrD, PCD, PCPlus4D} !== 128'h0) begin
      n_bad++;
      $display("FAIL midreset_async: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h want all 0",
               PCF, InstrD, PCD, PCPlus4D);
    end
    @(posedge clk);
    #1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    reset = 1'b1;
    model_pc = 32'h0;
    exp_last = '0;
    exp_q.delete();
    step(0, 0, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({InstrD, PCD, PCPlus4D} !== e || PCF !== model_pc) begin
      n_bad++;
      $display("FAIL midreset_resume: got %h %h %h pc %h want %h %h %h pc %h", InstrD,
               PCD, PCPlus4D, PCF, e.instr, e.pc, e.pc4, model_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_flush();
    test_wrap_and_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
